fifo_arbiter: RTL and testbench
===============================

# fifo_arbiter

Controller that sequences the team's 4-entry `fifo` storage between one producer (bus write side) and one consumer (state-machine pull side). The storage accepts at most one of push/pull per cycle and gives no occupancy information. This block adds the following:
- ready/valid handshakes on both sides;
- occupancy tracking and full/empty/threshold status;
- fair alternation when both sides contend in the same cycle;
- sticky error flags for the debug register.

It sits between the bus register file and each PIO state machine's TX or RX path.

## Interface
- `WIDTH`, 32, data word width (must equal storage width)
- `DEPTH`, 4, storage entries (fixed by storage; level width = 3)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; also drives storage reset
- `wr_valid`  in  1  producer offers `wr_data`
- `wr_data`  in  WIDTH  producer word
- `wr_ready`  out  1  word accepted this cycle when `wr_valid && wr_ready`
- `rd_valid`  out  1  `rd_data` holds a word for the consumer
- `rd_data`  out  WIDTH  consumer word (storage `dout`)
- `rd_ready`  in  1  consumer takes word when `rd_valid && rd_ready`
- `level`  out  3  words held in storage (0..4), excludes word presented on `rd_data`
- `full`  out  1  `level == 4`
- `empty`  out  1  `level == 0`
- `thresh`  in  3  status threshold
- `below_thresh`  out  1  `level < thresh`, combinational from registered `level`
- `overflow`  out  1  sticky: `wr_valid && full` seen
- `stall`  out  1  sticky: `rd_ready && !rd_valid && empty` seen
- `clear_flags`  in  1  clears both sticky flags

## Operation
- `pull_ok = !empty && (!rd_valid || rd_ready)`.
- `push_ok = wr_valid && !full`.
- `turn` register has two values, PUSH and PULL; it resets to PUSH.
- Conflict: `push_ok && pull_ok`.
  - Grant goes to `turn`.
  - `turn` flips to the other side after every conflict cycle only.
- `wr_ready = !full && !(pull_ok && turn == PULL)`. It must not depend on `wr_valid`.
- `push` fires when `wr_valid && wr_ready`.
- `pull` fires when `pull_ok` and not (`push_ok && turn == PUSH`).
- `push` and `pull` are never both asserted. Storage push-priority is therefore never exercised.
- `level`: +1 on push, −1 on pull, saturation impossible by construction.
- `rd_valid` update:
  - set on pull;
  - cleared on `rd_ready` without pull;
  - held on pull with `rd_ready` (back-to-back stream).
- `rd_data` wiring: driven directly from storage `dout`, which holds until the next pull.
- Sticky flags:
  - set-condition wins over `clear_flags` in the same cycle;
  - unaffected by grants.
- Reset values:
  - `level=0`, `full=0`, `empty=1`, `rd_valid=0`, `wr_ready=1`, `overflow=0`, `stall=0`, `turn=PUSH`;
  - storage contents and `rd_data` are don't-care.
- Reset mid-operation: all in-flight words are discarded, and nothing is pushed or pulled during a reset cycle.

## Timing
- Push in cycle N: `level`/`empty` update at N+1; earliest pull at N+1; `rd_valid` at N+2. Minimum write-to-read latency is 2 cycles.
- Pull in cycle N: `rd_valid=1` and new `rd_data` at N+1.
- Sustained streaming with both sides always active:
  - level ≥ 1 and consumer always ready: push and pull alternate, giving 0.5 words/cycle each side;
  - uncontended side: 1 word/cycle.
- Full: `wr_ready=0` until a pull completes; `level` becomes 3 the next cycle, and `wr_ready` returns that cycle (subject to `turn`).
- Empty with `rd_valid=1`, not consumed: no pull; `rd_data` stable.
- `rd_valid=1` with `rd_ready=0`: `pull_ok=0`, so the producer is granted every cycle until full.

## Structure
- Shared package `pio_fifo_pkg`:
  - `FIFO_WIDTH=32`, `FIFO_DEPTH=4`, `LEVEL_W=3`;
  - enum `grant_t {PUSH, PULL}` for `turn`.
- One sub-module: existing `fifo` storage instance (`u_store`), with `push`/`pull`/`din`/`dout` wired as above.
- Remaining logic:
  - `level` counter;
  - `turn` flip-flop;
  - `rd_valid` flip-flop;
  - two sticky flags;
  - combinational grant logic.

## Test plan
- Reset then push 0xA0..0xA3 with `rd_ready=0` → `level` 1,2,3,4; `full=1` after 4th; 5th `wr_valid` sees `wr_ready=0`, `overflow=1`.
- Drain the full FIFO with `rd_ready=1` → `rd_data` 0xA0,0xA1,0xA2,0xA3 in order on consecutive cycles; `empty=1` after 4th pull; extra `rd_ready` sets `stall=1`.
- Level 2, `wr_valid=1` and `rd_ready=1` continuously:
  - grants alternate PUSH, PULL, PUSH...;
  - `level` oscillates 2↔3;
  - no word lost or duplicated over 100 words.
- Single push 0x55 into empty → `empty=0` at N+1, `rd_valid=1` with `rd_data=0x55` at N+2.
- `thresh=3`: at `level` 2 `below_thresh=1`, at 3 `below_thresh=0`. Assert `clear_flags` while a new overflow occurs → `overflow` stays 1.
- Reset asserted at `level=3`, `rd_valid=1` → next cycle `level=0`, `rd_valid=0`, `empty=1`, flags 0, `turn=PUSH`.

Source files
------------

// File: rtl/pio_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pio_fifo_pkg
// Shared constants and types for the PIO FIFO controller and its storage.
//   FIFO_WIDTH : data word width
//   FIFO_DEPTH : number of storage entries
//   LEVEL_W    : width of the occupancy count (must hold 0..FIFO_DEPTH)
//   grant_t    : which side wins a same-cycle push/pull conflict
// -----------------------------------------------------------------------------
package pio_fifo_pkg;

    localparam int FIFO_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int LEVEL_W    = 3;

    typedef enum logic {
        PUSH = 1'b0,
        PULL = 1'b1
    } grant_t;

    // Side that gets the next conflict after the given side has been served.
    function automatic grant_t other_side(input grant_t g);
        return (g == PUSH) ? PULL : PUSH;
    endfunction

endpackage

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Plain circular-buffer storage. It accepts at most one of push/pull per cycle
// (push wins if both are asserted) and gives no occupancy information; the
// caller is responsible for never pushing when full or pulling when empty.
//   clk   : clock
//   reset : synchronous active-high reset (pointers only; contents undefined)
//   push  : write din at the write pointer
//   pull  : load the oldest word into dout
//   din   : write data
//   dout  : registered read data, holds until the next pull
// -----------------------------------------------------------------------------
module fifo
    import pio_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pull,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_dout;

    logic w_do_push;
    logic w_do_pull;

    assign w_do_push = push && !reset;
    assign w_do_pull = pull && !push && !reset;

    // Array kept free of reset so it maps onto RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
        if (w_do_pull) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pull) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/fifo_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_arbiter
// Sequences the 4-entry fifo storage between a producer and a consumer with
// ready/valid handshakes, occupancy/status tracking, fair alternation on
// contention and sticky debug error flags.
//   clk, reset     : clock, synchronous active-high reset (also resets storage)
//   wr_valid/ready : producer handshake, wr_data is the offered word
//   rd_valid/ready : consumer handshake, rd_data is storage dout
//   level          : words held in storage (excludes the word on rd_data)
//   full / empty   : level == DEPTH / level == 0
//   thresh         : status threshold, below_thresh = level < thresh
//   overflow       : sticky, write attempted while full
//   stall          : sticky, read attempted with nothing available
//   clear_flags    : clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module fifo_arbiter
    import pio_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               wr_ready,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    input  logic               rd_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty,
    input  logic [LEVEL_W-1:0] thresh,
    output logic               below_thresh,
    output logic               overflow,
    output logic               stall,
    input  logic               clear_flags
);

    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

    logic [LEVEL_W-1:0] r_level;
    grant_t             r_turn;
    logic               r_rd_valid;
    logic               r_overflow;
    logic               r_stall;

    logic w_full;
    logic w_empty;
    logic w_pull_ok;
    logic w_push_ok;
    logic w_conflict;
    logic w_wr_ready;
    logic w_push;
    logic w_pull;
    logic w_set_overflow;
    logic w_set_stall;

    assign w_full  = (r_level == LEVEL_FULL);
    assign w_empty = (r_level == '0);

    // A pull is possible when storage has a word and the output slot is free
    // or being emptied this cycle.
    assign w_pull_ok  = !w_empty && (!r_rd_valid || rd_ready);
    assign w_push_ok  = wr_valid && !w_full;
    assign w_conflict = w_push_ok && w_pull_ok;

    // wr_ready deliberately excludes wr_valid so the producer may wait on it.
    assign w_wr_ready = !w_full && !(w_pull_ok && (r_turn == PULL));
    assign w_push     = wr_valid && w_wr_ready;
    assign w_pull     = w_pull_ok && !(w_push_ok && (r_turn == PUSH));

    assign w_set_overflow = wr_valid && w_full;
    assign w_set_stall    = rd_ready && !r_rd_valid && w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level    <= '0;
            r_turn     <= PUSH;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            // push and pull are mutually exclusive, so the count never
            // moves by more than one and cannot leave 0..DEPTH.
            if (w_push) begin
                r_level <= r_level + 1'b1;
            end else if (w_pull) begin
                r_level <= r_level - 1'b1;
            end

            // Alternation only advances on genuine contention, so a lone
            // side never loses its place in line.
            if (w_conflict) begin
                r_turn <= other_side(r_turn);
            end

            if (w_pull) begin
                r_rd_valid <= 1'b1;
            end else if (rd_ready) begin
                r_rd_valid <= 1'b0;
            end

            r_overflow <= w_set_overflow || (r_overflow && !clear_flags);
            r_stall    <= w_set_stall    || (r_stall    && !clear_flags);
        end
    end

    fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pull  (w_pull),
        .din   (wr_data),
        .dout  (rd_data)
    );

    assign wr_ready     = w_wr_ready;
    assign rd_valid     = r_rd_valid;
    assign level        = r_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign below_thresh = (r_level < thresh);
    assign overflow     = r_overflow;
    assign stall        = r_stall;

endmodule

// File: tb/tb_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_arbiter
// Drives directed and random traffic into fifo_arbiter. A queue-based reference
// model tracks occupancy, the presented word, the contention turn and the
// sticky flags; accepted words go into a scoreboard that a separate monitor
// drains whenever the DUT presents a word on rd_data.
// -----------------------------------------------------------------------------
module tb_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic [2:0]  level;
    logic        full;
    logic        empty;
    logic [2:0]  thresh;
    logic        below_thresh;
    logic        overflow;
    logic        stall;
    logic        clear_flags;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_cnt = 0;        // words inside storage
    bit          m_pres = 0;       // a word is presented to the consumer
    bit          m_turn_pull = 0;  // next conflict goes to the consumer
    bit          m_ovf = 0;
    bit          m_stall = 0;
    int          m_consumed = 0;
    int          mon_consumed = 0;
    logic [31:0] sb_q [$];         // words accepted, not yet consumed, in order

    fifo_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .thresh       (thresh),
        .below_thresh (below_thresh),
        .overflow     (overflow),
        .stall        (stall),
        .clear_flags  (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model exactly as the rules say the hardware must.
    task automatic step(input bit rst, input bit wv, input logic [31:0] wd,
                        input bit rr, input bit clr, input logic [2:0] th);
        bit e_full, e_empty, pull_ok, push_ok, e_wr_ready, do_push, do_pull;
        bit set_ovf, set_st;
        @(negedge clk);
        reset       = rst;
        wr_valid    = wv;
        wr_data     = wd;
        rd_ready    = rr;
        clear_flags = clr;
        thresh      = th;
        #1;
        e_full     = (m_cnt == 4);
        e_empty    = (m_cnt == 0);
        pull_ok    = !e_empty && (!m_pres || rr);
        push_ok    = wv && !e_full;
        e_wr_ready = !e_full && !(pull_ok && m_turn_pull);
        do_push    = wv && e_wr_ready;
        do_pull    = pull_ok && !(push_ok && !m_turn_pull);
        if (!rst) begin
            chk("level",        32'(level),        32'(m_cnt));
            chk("full",         32'(full),         32'(e_full));
            chk("empty",        32'(empty),        32'(e_empty));
            chk("rd_valid",     32'(rd_valid),     32'(m_pres));
            chk("wr_ready",     32'(wr_ready),     32'(e_wr_ready));
            chk("below_thresh", 32'(below_thresh), 32'(m_cnt < int'(th)));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("stall",        32'(stall),        32'(m_stall));
        end
        if (rst) begin
            m_cnt       = 0;
            m_pres      = 0;
            m_turn_pull = 0;
            m_ovf       = 0;
            m_stall     = 0;
            sb_q.delete();
        end else begin
            if (m_pres && rr) m_consumed++;
            set_ovf = wv && e_full;
            set_st  = rr && !m_pres && e_empty;
            m_ovf   = set_ovf || (m_ovf && !clr);
            m_stall = set_st  || (m_stall && !clr);
            if (push_ok && pull_ok) m_turn_pull = !m_turn_pull;
            if (do_pull) begin
                m_cnt--;
                m_pres = 1;
            end else if (rr) begin
                m_pres = 0;
            end
            if (do_push) begin
                m_cnt++;
                sb_q.push_back(wd);
            end
        end
    endtask

    // Monitor: whenever a word is presented it must be the oldest outstanding
    // one; it leaves the scoreboard when the consumer takes it.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b0 && rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h expected=none at %0t", rd_data, $time);
            end else begin
                chk("rd_data", rd_data, sb_q[0]);
                if (rd_ready) begin
                    $display("RD word %08h level %0d", sb_q[0], level);
                    void'(sb_q.pop_front());
                    mon_consumed++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        clear_flags = 1'b0; thresh = 3'd0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Fill with consumer stalled until full, then one write while full.
        for (int i = 0; i < 7; i++) step(0, 1, 32'hA0 + 32'(i), 0, 0, 0);
        step(0, 1, 32'hAF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("overflow_after_fill", 32'(overflow), 32'd1);

        // Drain, then one more read with nothing left.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("stall_after_drain", 32'(stall), 32'd1);
        step(0, 0, 0, 0, 1, 0);

        // Bring level to 2 then stream both sides continuously.
        step(0, 1, 32'hB000, 0, 0, 0);
        step(0, 1, 32'hB001, 0, 0, 0);
        while (m_cnt < 2) step(0, 1, 32'hB002, 0, 0, 0);
        for (int i = 0; i < 200; i++) step(0, 1, 32'hC000 + 32'(i), 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);

        // Single push into empty: status one cycle later, data two.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h55, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("single_rd_data", rd_data, 32'h55);
        step(0, 0, 0, 1, 0, 0);

        // Threshold edge and clear racing a new overflow.
        for (int i = 0; i < 8; i++) step(0, 1, 32'hD0 + 32'(i), 0, 0, 3'd3);
        step(0, 1, 32'hDF, 0, 1, 3'd3);
        step(0, 0, 0, 0, 0, 3'd3);
        chk("overflow_set_beats_clear", 32'(overflow), 32'd1);
        step(0, 0, 0, 0, 1, 3'd3);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 3'd3);

        // Reset mid-operation with words in flight.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 32'hE0 + 32'(i), 0, 0, 0);
        step(1, 1, 32'hEE, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_level", 32'(level), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            d = $urandom;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 70, d,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 5,
                 3'($urandom_range(0, 7)));
        end
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);

        @(negedge clk);
        #5;
        chk("consumed_count", 32'(mon_consumed), 32'(m_consumed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
